avalon_multi_timer: RTL and testbench
=====================================

// Module: avalon_multi_timer
// PURPOSE
//  Multi-channel interval timer, Avalon-MM slave, NUM_CH independent down-counters with per-channel prescaler.
//  Each channel supports one-shot/continuous mode, snapshot, timeout flag and IRQ.
//  Sits on the Nios II data bus beside the pixel-buffer/VGA peripherals.
//  Provides frame pacing and periodic ticks without the HPS/CPU polling.
// PARAMETERS
//  NUM_CH        4     number of channels (1..16)
//  CNT_W         32    counter/period width (1..DATA_W)
//  DATA_W        32    Avalon data width
//  PRESCALE_W    8     prescaler divider field width (<=8)
//  RESET_PERIOD  4999  period and counter value after reset, all channels
//  ADDR_W        $clog2(NUM_CH)+2  derived localparam, not overridable
// PORTS
//  clk         in   1           system clock
//  reset       in   1           synchronous, active-high reset
//  address     in   ADDR_W      {channel, reg[1:0]}
//  chipselect  in   1           slave select
//  write_n     in   1           active-low write
//  writedata   in   DATA_W      write data
//  readdata    out  DATA_W      registered read data
//  irq         out  1           OR of irq_vec
//  irq_vec     out  NUM_CH      per-channel TO & ITO
// BEHAVIOUR
//  Reg map per channel (reg[1:0]):
//   0 STATUS   [0] TO, [1] RUN (read-only). Any write clears TO.
//   1 CONTROL  [0] ITO, [1] CONT, [2] START strobe, [3] STOP strobe, [15:8] PRESC.
//      START/STOP are not stored and read back as 0.
//   2 PERIOD   CNT_W bits; upper writedata bits are ignored; reads are zero-extended.
//   3 SNAP     any write captures the live counter; reads return the captured value.
//  wr = chipselect & ~write_n. Read latency is 1 cycle (readdata registered every clk).
//  Reads have no side effects. Unmapped channel index (>= NUM_CH) reads 0 and ignores writes.
//  Reset: readdata=0, irq=0, irq_vec=0, TO=0, RUN=0, CONTROL=0, SNAP=0, PERIOD=count=RESET_PERIOD.
//  Prescaler: per-channel pcnt; tick when pcnt==PRESC, then pcnt<=0, else pcnt+1.
//   PRESC=0 gives a tick every cycle. pcnt is cleared on START and on PERIOD write.
//  Counter, on tick while RUN:
//   count==0: count<=PERIOD; TO<=1; RUN<=CONT.
//   otherwise: count<=count-1.
//   Timeout interval is (PERIOD+1)*(PRESC+1) clk cycles.
//  PERIOD write: count<=new value next cycle, RUN<=0 (force reload, restart required).
//  START: RUN<=1 next cycle, count unchanged (resumes). STOP: RUN<=0, count holds.
//  START and STOP in the same write: START wins.
//  STOP and reaching zero in the same cycle: reload and TO still occur, RUN<=0.
//  TO set and STATUS write in the same cycle: set wins, so no event is lost.
//  PERIOD=0 with CONT=1: TO every tick. PERIOD=0 with CONT=0: one timeout, then stop.
//  SNAP write on the cycle count changes: the pre-update value is captured.
//  irq_vec[i] = TO[i] & ITO[i], combinational from registers (no extra latency).
//  Mid-operation reset returns everything to reset values on the next edge; a pending TO is lost.
// STRUCTURE
//  Package amt_pkg: register offsets, CONTROL/STATUS bit positions, field widths.
//  Sub-module amt_channel (one per channel, generate loop): prescaler, counter, TO/RUN, SNAP.
//  Top level: address decode, per-channel write strobes, registered read mux, irq OR.
// TESTING
//  1 Reset, read all regs -> PERIOD=4999, STATUS=0, CONTROL=0, SNAP=0, irq=0.
//  2 ch0 PERIOD=3, CONTROL=ITO|CONT|START, PRESC=0 -> TO/irq every 4 clk; RUN stays 1.
//  3 ch1 PERIOD=2, PRESC=1, one-shot START -> TO after 6 clk, RUN=0, count reloaded to 2.
//  4 TO pending, STATUS write on the same cycle as a new timeout -> TO remains 1.
//  5 PERIOD write while running -> RUN=0 next cycle, count=new value; START resumes.
//  6 Channels 0..3 with distinct periods -> irq_vec bits independent; irq = OR; SNAP values match.

Source files
------------

// File: rtl/amt_pkg.sv
// Shared definitions for the multi-channel interval timer: register offsets,
// CONTROL/STATUS bit positions and field limits.
package amt_pkg;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } amt_reg_e;

  localparam int STAT_TO_BIT    = 0;
  localparam int STAT_RUN_BIT   = 1;

  localparam int CTRL_ITO_BIT   = 0;
  localparam int CTRL_CONT_BIT  = 1;
  localparam int CTRL_START_BIT = 2;
  localparam int CTRL_STOP_BIT  = 3;
  localparam int CTRL_PRESC_LSB = 8;

  localparam int PRESC_MAX_W    = 8;

endpackage

// File: rtl/amt_channel.sv
// One timer channel: prescaler, down-counter with reload, TO/RUN flags,
// snapshot register and the per-channel interrupt request.
module amt_channel
  import amt_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          DATA_W       = 32,
  parameter int          PRESCALE_W   = 8,
  parameter int unsigned RESET_PERIOD = 4999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_status_i,
  input  logic              wr_control_i,
  input  logic              wr_period_i,
  input  logic              wr_snap_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  amt_reg_e          reg_sel_i,
  output logic [DATA_W-1:0] rd_o,
  output logic              irq_o
);

  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      period_q, period_d;
  logic [CNT_W-1:0]      snap_q, snap_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  to_q, to_d;
  logic                  run_q, run_d;
  logic                  ito_q, ito_d;
  logic                  cont_q, cont_d;

  logic tick, expire, start, stop;

  assign start  = wr_control_i & wdata_i[CTRL_START_BIT];
  assign stop   = wr_control_i & wdata_i[CTRL_STOP_BIT];
  assign tick   = (pcnt_q == presc_q);
  assign expire = tick & run_q & (count_q == '0);

  always_comb begin
    pcnt_d   = tick ? '0 : pcnt_q + PRESCALE_W'(1);
    count_d  = count_q;
    period_d = period_q;
    snap_d   = snap_q;
    presc_d  = presc_q;
    to_d     = to_q;
    run_d    = run_q;
    ito_d    = ito_q;
    cont_d   = cont_q;

    if (start || wr_period_i) pcnt_d = '0;

    if (tick && run_q) begin
      if (count_q == '0) begin
        count_d = period_q;
        run_d   = cont_q;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end

    // A timeout landing on the same edge as a clearing write must survive.
    if (wr_status_i) to_d = 1'b0;
    if (expire)      to_d = 1'b1;

    if (wr_control_i) begin
      ito_d   = wdata_i[CTRL_ITO_BIT];
      cont_d  = wdata_i[CTRL_CONT_BIT];
      presc_d = wdata_i[CTRL_PRESC_LSB +: PRESCALE_W];
      if (stop)  run_d = 1'b0;
      if (start) run_d = 1'b1;
    end

    if (wr_period_i) begin
      period_d = wdata_i[CNT_W-1:0];
      count_d  = wdata_i[CNT_W-1:0];
      run_d    = 1'b0;
    end

    if (wr_snap_i) snap_d = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= RST_VAL;
      period_q <= RST_VAL;
      snap_q   <= '0;
      pcnt_q   <= '0;
      presc_q  <= '0;
      to_q     <= 1'b0;
      run_q    <= 1'b0;
      ito_q    <= 1'b0;
      cont_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
      snap_q   <= snap_d;
      pcnt_q   <= pcnt_d;
      presc_q  <= presc_d;
      to_q     <= to_d;
      run_q    <= run_d;
      ito_q    <= ito_d;
      cont_q   <= cont_d;
    end
  end

  always_comb begin
    rd_o = '0;
    unique case (reg_sel_i)
      REG_STATUS: begin
        rd_o[STAT_TO_BIT]  = to_q;
        rd_o[STAT_RUN_BIT] = run_q;
      end
      REG_CONTROL: begin
        rd_o[CTRL_ITO_BIT]                  = ito_q;
        rd_o[CTRL_CONT_BIT]                 = cont_q;
        rd_o[CTRL_PRESC_LSB +: PRESCALE_W]  = presc_q;
      end
      REG_PERIOD: rd_o = DATA_W'(period_q);
      REG_SNAP:   rd_o = DATA_W'(snap_q);
      default:    rd_o = '0;
    endcase
  end

  assign irq_o = to_q & ito_q;

endmodule

// File: rtl/avalon_multi_timer.sv
// Avalon-MM multi-channel interval timer: address decode into per-channel
// write strobes, registered read mux and interrupt aggregation.
module avalon_multi_timer
  import amt_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int          DATA_W       = 32,
  parameter int          PRESCALE_W   = 8,
  parameter int unsigned RESET_PERIOD = 4999,
  localparam int         ADDR_W       = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  // One spare bit keeps the channel field non-empty even when NUM_CH == 1.
  localparam int SEL_W = ADDR_W + 1;

  // Bus timing: a write takes effect on the edge where chipselect & ~write_n
  // is seen; readdata always holds the addressed register as of the previous
  // edge (fixed one-cycle latency, no wait states, reads have no side effects).
  logic              wr;
  logic [SEL_W-1:0]  addr_ext;
  logic [SEL_W-1:0]  ch_sel;
  amt_reg_e          reg_sel;
  logic [DATA_W-1:0] ch_rd [NUM_CH];
  logic [DATA_W-1:0] readdata_q, readdata_d;

  assign wr       = chipselect & ~write_n;
  assign addr_ext = {1'b0, address};
  assign ch_sel   = addr_ext >> 2;
  assign reg_sel  = amt_reg_e'(address[1:0]);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = wr & (ch_sel == SEL_W'(i));

    amt_channel #(
      .CNT_W        (CNT_W),
      .DATA_W       (DATA_W),
      .PRESCALE_W   (PRESCALE_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .wr_status_i  (hit & (reg_sel == REG_STATUS)),
      .wr_control_i (hit & (reg_sel == REG_CONTROL)),
      .wr_period_i  (hit & (reg_sel == REG_PERIOD)),
      .wr_snap_i    (hit & (reg_sel == REG_SNAP)),
      .wdata_i      (writedata),
      .reg_sel_i    (reg_sel),
      .rd_o         (ch_rd[i]),
      .irq_o        (irq_vec[i])
    );
  end

  // Unmapped channel indices fall through to zero.
  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == SEL_W'(i)) readdata_d = ch_rd[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Self-checking bench for avalon_multi_timer: register map, timeout timing,
// flag races, period reload, multi-channel independence and reset.
module tb_avalon_multi_timer;
  import amt_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;

  logic [DATA_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  avalon_multi_timer dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
  );

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ctrl(input logic ito, input logic cont, input logic start,
                                       input logic stop, input logic [7:0] presc);
    logic [31:0] w;
    w = '0;
    w[0] = ito;
    w[1] = cont;
    w[2] = start;
    w[3] = stop;
    w[15:8] = presc;
    return w;
  endfunction

  task automatic bus_write(input int ch, input logic [1:0] r, input logic [31:0] data);
    logic [1:0] c;
    c = ch[1:0];
    address    = {c, r};
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input int ch, input logic [1:0] r, input logic [31:0] exp, input string tag);
    logic [1:0] c;
    c = ch[1:0];
    exp_q.push_back(exp);
    address    = {c, r};
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick(1);
    chipselect = 1'b0;
    check_val(tag, readdata, exp_q.pop_front());
  endtask

  function automatic logic [31:0] live_count(input int p, input int n);
    return p - (n % (p + 1));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int periods [4];
    int first_to [4];
    logic [3:0] exp_vec;
    int rp, rq, n;

    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    tick(3);
    check_val("rst_readdata", readdata, 0);
    check_val("rst_irq", irq, 0);
    check_val("rst_irq_vec", irq_vec, 0);
    reset = 1'b0;

    // 1: reset values of every register
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bus_read(ch, REG_STATUS, 0, "rst_status");
      bus_read(ch, REG_CONTROL, 0, "rst_control");
      bus_read(ch, REG_PERIOD, 4999, "rst_period");
      bus_read(ch, REG_SNAP, 0, "rst_snap");
    end

    // 2: ch0 continuous, PERIOD=3, PRESC=0 -> TO every 4 clocks
    bus_write(0, REG_PERIOD, 3);
    bus_write(0, REG_CONTROL, ctrl(1, 1, 1, 0, 0));
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      check_val("c0_pre_to", irq_vec, 0);
    end
    tick(1);
    check_val("c0_first_to", irq_vec, 4'b0001);
    check_val("c0_first_irq", irq, 1);
    bus_write(0, REG_STATUS, $urandom);
    check_val("c0_cleared", irq_vec, 0);
    for (int k = 1; k <= 2; k++) begin
      tick(1);
      check_val("c0_gap", irq_vec, 0);
    end
    tick(1);
    check_val("c0_second_to", irq_vec, 4'b0001);
    bus_read(0, REG_STATUS, 3, "c0_status_run");

    // 4: clearing write on the same edge as the next timeout
    tick(2);
    bus_write(0, REG_STATUS, $urandom);
    check_val("c0_race_irq", irq_vec, 4'b0001);
    bus_read(0, REG_STATUS, 3, "c0_race_status");
    bus_write(0, REG_STATUS, 0);
    check_val("c0_clear_again", irq_vec, 0);
    bus_write(0, REG_CONTROL, ctrl(1, 0, 0, 1, 0));
    bus_write(0, REG_STATUS, 0);
    bus_read(0, REG_STATUS, 0, "c0_stopped");
    bus_read(0, REG_CONTROL, 1, "c0_ctrl_readback");

    // 3: ch1 one-shot, PERIOD=2, PRESC=1 -> TO after 6 clocks
    bus_write(1, REG_PERIOD, 2);
    bus_write(1, REG_CONTROL, ctrl(1, 0, 1, 0, 1));
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      check_val("c1_pre_to", irq_vec, 0);
    end
    tick(1);
    check_val("c1_to", irq_vec, 4'b0010);
    bus_read(1, REG_STATUS, 1, "c1_oneshot_status");
    bus_write(1, REG_SNAP, $urandom);
    bus_read(1, REG_SNAP, 2, "c1_reloaded");
    bus_write(1, REG_STATUS, $urandom);
    check_val("c1_cleared", irq_vec, 0);

    // 5: PERIOD write while running forces a stop and reload
    bus_write(2, REG_PERIOD, 10);
    bus_write(2, REG_CONTROL, ctrl(0, 1, 1, 0, 0));
    tick(4);
    bus_write(2, REG_PERIOD, 7);
    bus_read(2, REG_STATUS, 0, "c2_stopped_by_period");
    bus_write(2, REG_SNAP, $urandom);
    bus_read(2, REG_SNAP, 7, "c2_reload_val");
    bus_write(2, REG_CONTROL, ctrl(0, 1, 1, 0, 0));
    tick(3);
    bus_write(2, REG_SNAP, $urandom);
    bus_read(2, REG_STATUS, 2, "c2_resumed");
    bus_read(2, REG_SNAP, 4, "c2_snap_pre_update");

    // 6: four channels with distinct periods, started on consecutive edges
    periods = '{2, 3, 4, 5};
    for (int i = 0; i < 4; i++) first_to[i] = i + periods[i] + 1;
    for (int i = 0; i < 4; i++) bus_write(i, REG_PERIOD, periods[i]);
    for (int i = 0; i < 4; i++) bus_write(i, REG_STATUS, $urandom);
    for (int i = 0; i < 4; i++) bus_write(i, REG_CONTROL, ctrl(1, 1, 1, 0, 0));
    for (int t = 3; t <= 10; t++) begin
      exp_vec = '0;
      for (int i = 0; i < 4; i++) exp_vec[i] = (t >= first_to[i]);
      check_val($sformatf("multi_vec_t%0d", t), irq_vec, exp_vec);
      check_val($sformatf("multi_irq_t%0d", t), irq, |exp_vec);
      if (t != 10) tick(1);
    end
    for (int i = 0; i < 4; i++) bus_write(i, REG_SNAP, $urandom);
    for (int i = 0; i < 4; i++)
      bus_read(i, REG_SNAP, live_count(periods[i], 10), $sformatf("multi_snap_c%0d", i));
    for (int i = 0; i < 4; i++) bus_write(i, REG_CONTROL, ctrl(0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) bus_write(i, REG_STATUS, 0);
    check_val("multi_all_clear", irq_vec, 0);

    // randomised one-shot interval on ch3: (PERIOD+1)*(PRESC+1)
    rp = $urandom_range(1, 20);
    rq = $urandom_range(0, 3);
    bus_write(3, REG_PERIOD, rp);
    bus_write(3, REG_STATUS, 0);
    bus_write(3, REG_CONTROL, ctrl(1, 0, 1, 0, rq[7:0]));
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!irq_vec[3] && n < 300);
    check_val("rand_interval", n, (rp + 1) * (rq + 1));
    bus_read(3, REG_CONTROL, ctrl(1, 0, 0, 0, rq[7:0]), "rand_ctrl_readback");
    bus_read(3, REG_STATUS, 1, "rand_status");

    // START and STOP together: START wins
    bus_write(0, REG_CONTROL, ctrl(0, 0, 1, 1, 0));
    bus_read(0, REG_STATUS, 2, "start_stop_same");

    // mid-operation reset drops pending TO and restores defaults
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_val("mid_rst_readdata", readdata, 0);
    check_val("mid_rst_irq", irq, 0);
    bus_read(3, REG_STATUS, 0, "mid_rst_status");
    bus_read(3, REG_PERIOD, 4999, "mid_rst_period");
    bus_read(0, REG_CONTROL, 0, "mid_rst_control");

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
